i2c_txn_arbiter: RTL



---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_rr_arbiter.sv | 57 +++++
 rtl/i2c_txn_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C transaction arbiter.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_RUN,
      ST_CHAIN,
      ST_FINISH
   } arb_state_t;

   localparam int MAX_REQ     = 4;
   localparam int DEC_EDGE_RD = 2;
   localparam int DEC_EDGE_WR = 9;

   // SCL falling edge, counted from the last byte event, where the master decides stop vs. repeat start
   function automatic logic [3:0] decision_edge(input logic rw);
      return rw ? 4'(DEC_EDGE_RD) : 4'(DEC_EDGE_WR);
   endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Round-robin arbiter with one-hot grant; lock pins the grant to lock_idx.
module i2c_rr_arbiter
   import i2c_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          lock,
   input  logic [IW-1:0] lock_idx,
   input  logic          update,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          valid
);

   logic [IW-1:0] ptr_reg;
   logic [IW-1:0] ptr_next;
   int            idx;

   // Descending scan so the requester closest after ptr_reg wins
   always_comb begin
      grant_idx = ptr_reg;
      valid     = 1'b0;
      idx       = 0;
      if (lock) begin
         grant_idx = lock_idx;
         valid     = req[lock_idx];
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr_reg) + i;
            if (idx >= N) idx = idx - N;
            if (req[IW'(idx)]) begin
               grant_idx = IW'(idx);
               valid     = 1'b1;
            end
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign grant[gi] = valid && (grant_idx == IW'(gi));
   end

   assign ptr_next = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_reg <= '0;
      end else if (update && valid) begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master between NUM_REQ requesters with byte-counted, chainable commands.
// Optional watchdog that resets a stuck master: define I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter
   import i2c_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int LEN_W       = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                     i2c_core_clk_i,
   input  logic                     reset_ni,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [NUM_REQ-1:0]       req_rw_i,
   input  logic [NUM_REQ*LEN_W-1:0] req_len_i,
   input  logic [NUM_REQ-1:0]       req_chain_i,
   output logic [NUM_REQ-1:0]       ack_o,
   output logic [NUM_REQ-1:0]       done_o,
   output logic                     err_o,
   output logic                     busy_o,
   input  logic                     fifo_full_i,
   input  logic                     fifo_empty_i,
   output logic                     m_full_o,
   output logic                     m_empty_o,
   output logic                     m_enable_o,
   output logic                     m_repeat_start_o,
   output logic                     m_rw_o,
   input  logic                     m_r_fifo_en_i,
   input  logic                     m_w_fifo_en_i,
   input  logic                     m_scl_en_i,
   input  logic                     i2c_scl_i,
   output logic                     m_rst_no
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = LEN_W + 1;

   if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYC < 2) begin : g_bad_cfg
      $error("i2c_txn_arbiter: unsupported parameter set");
   end

   function automatic logic [CW-1:0] len_fix(input logic [LEN_W-1:0] l);
      return (l == '0) ? CW'(1) : {1'b0, l};
   endfunction

   arb_state_t         state_reg, state_next;
   logic [IW-1:0]      g_reg, g_next;
   logic               rw_reg, rw_next;
   logic [CW-1:0]      len_reg, len_next;
   logic               chain_reg, chain_next;
   logic               pend_rw_reg, pend_rw_next;
   logic [CW-1:0]      pend_len_reg, pend_len_next;
   logic               pend_chain_reg, pend_chain_next;
   logic [CW-1:0]      cnt_reg, cnt_next, cnt_inc;
   logic               last_reg, last_next;
   logic [3:0]         fall_reg, fall_next;
   logic [NUM_REQ-1:0] ack_reg, ack_next;
   logic [NUM_REQ-1:0] done_reg, done_next;
   logic               err_reg, err_next;
   logic               en_reg, en_next;
   logic               rs_reg, rs_next;
   logic [3:0]         sync_q, sync_qq, sync_in;
   logic               scl_fall, scl_en_fall, byte_ev, hold, timed_out;
   logic [NUM_REQ-1:0] arb_grant, g_onehot;
   logic [IW-1:0]      arb_idx;
   logic               arb_valid;

   i2c_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
      .clk       (i2c_core_clk_i),
      .rst_n     (reset_ni),
      .req       (req_i),
      .lock      (state_reg != ST_IDLE),
      .lock_idx  (g_reg),
      .update    (state_reg == ST_IDLE),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .valid     (arb_valid)
   );

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_owner
      assign g_onehot[gi] = (g_reg == IW'(gi));
   end

   // Bit order: {scl, scl_en, r_fifo_en, w_fifo_en}; edges act one cycle after they occur
   assign sync_in     = {i2c_scl_i, m_scl_en_i, m_r_fifo_en_i, m_w_fifo_en_i};
   assign scl_fall    = !sync_q[3] && sync_qq[3];
   assign scl_en_fall = !sync_q[2] && sync_qq[2];
   assign byte_ev     = rw_reg ? (sync_q[0] && !sync_qq[0]) : (sync_q[1] && !sync_qq[1]);
   assign cnt_inc     = (cnt_reg == '1) ? cnt_reg : cnt_reg + CW'(1);

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYC);
   logic [WW-1:0] wd_reg, wd_next;
   logic [1:0]    mrst_reg, mrst_next;
   logic          tout_reg, tout_next;

   assign timed_out = tout_reg;
   assign m_rst_no  = (mrst_reg == 2'd0);

   always_ff @(posedge i2c_core_clk_i) begin
      if (!reset_ni) begin
         wd_reg   <= '0;
         mrst_reg <= 2'd0;
         tout_reg <= 1'b0;
      end else begin
         wd_reg   <= wd_next;
         mrst_reg <= mrst_next;
         tout_reg <= tout_next;
      end
   end
`else
   assign timed_out = 1'b0;
   assign m_rst_no  = 1'b1;
`endif

   always_comb begin
      state_next      = state_reg;
      g_next          = g_reg;
      rw_next         = rw_reg;
      len_next        = len_reg;
      chain_next      = chain_reg;
      pend_rw_next    = pend_rw_reg;
      pend_len_next   = pend_len_reg;
      pend_chain_next = pend_chain_reg;
      cnt_next        = cnt_reg;
      last_next       = last_reg;
      fall_next       = fall_reg;
      en_next         = en_reg;
      rs_next         = rs_reg;
      ack_next        = '0;
      done_next       = '0;
      err_next        = 1'b0;
      hold            = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      wd_next   = '0;
      mrst_next = mrst_reg;
      tout_next = (state_reg == ST_FINISH) ? 1'b0 : tout_reg;
      if (mrst_reg != 2'd0) begin
         hold      = 1'b1;
         mrst_next = mrst_reg - 2'd1;
         if (mrst_reg == 2'd1) begin
            state_next = ST_FINISH;
            rs_next    = 1'b0;
            tout_next  = 1'b1;
         end
      end else if (state_reg == ST_RUN || state_reg == ST_CHAIN) begin
         if (byte_ev) begin
            wd_next = '0;
         end else if (wd_reg == WW'(TIMEOUT_CYC - 1)) begin
            hold      = 1'b1;
            mrst_next = 2'd2;
         end else begin
            wd_next = wd_reg + WW'(1);
         end
      end
`endif
      if (!hold) begin
         case (state_reg)
            ST_IDLE: begin
               if (arb_valid) begin
                  ack_next   = arb_grant;
                  g_next     = arb_idx;
                  rw_next    = req_rw_i[arb_idx];
                  len_next   = len_fix(req_len_i[arb_idx*LEN_W +: LEN_W]);
                  chain_next = req_chain_i[arb_idx];
                  cnt_next   = '0;
                  last_next  = 1'b0;
                  state_next = ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               if (m_scl_en_i) begin
                  en_next    = 1'b0;
                  state_next = ST_RUN;
               end else begin
                  en_next = 1'b1;
               end
            end
            ST_RUN: begin
               if (scl_en_fall) begin
                  state_next = ST_FINISH;
               end else if (byte_ev) begin
                  cnt_next = cnt_inc;
                  if (!last_reg && cnt_inc >= len_reg) begin
                     last_next = 1'b1;
                     // Grant is locked to g_reg here, so arb_valid is req_i[g_reg]
                     if (chain_reg && arb_valid) begin
                        ack_next        = arb_grant;
                        pend_rw_next    = req_rw_i[g_reg];
                        pend_len_next   = len_fix(req_len_i[g_reg*LEN_W +: LEN_W]);
                        pend_chain_next = req_chain_i[g_reg];
                        rs_next         = 1'b1;
                        fall_next       = 4'd0;
                        state_next      = ST_CHAIN;
                     end
                  end
               end
            end
            ST_CHAIN: begin
               if (scl_en_fall) begin
                  rs_next    = 1'b0;
                  state_next = ST_FINISH;
               end else if (scl_fall) begin
                  if (fall_reg + 4'd1 == decision_edge(rw_reg)) begin
                     rs_next    = 1'b0;
                     cnt_next   = '0;
                     last_next  = 1'b0;
                     rw_next    = pend_rw_reg;
                     len_next   = pend_len_reg;
                     chain_next = pend_chain_reg;
                     state_next = ST_RUN;
                  end else begin
                     fall_next = fall_reg + 4'd1;
                  end
               end
            end
            ST_FINISH: begin
               done_next  = g_onehot;
               err_next   = (cnt_reg < len_reg) || timed_out;
               cnt_next   = '0;
               last_next  = 1'b0;
               en_next    = 1'b0;
               rs_next    = 1'b0;
               state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i2c_core_clk_i) begin
      if (!reset_ni) begin
         state_reg      <= ST_IDLE;
         g_reg          <= '0;
         rw_reg         <= 1'b0;
         len_reg        <= CW'(1);
         chain_reg      <= 1'b0;
         pend_rw_reg    <= 1'b0;
         pend_len_reg   <= CW'(1);
         pend_chain_reg <= 1'b0;
         cnt_reg        <= '0;
         last_reg       <= 1'b0;
         fall_reg       <= 4'd0;
         ack_reg        <= '0;
         done_reg       <= '0;
         err_reg        <= 1'b0;
         en_reg         <= 1'b0;
         rs_reg         <= 1'b0;
         sync_q         <= 4'b1000;
         sync_qq        <= 4'b1000;
      end else begin
         state_reg      <= state_next;
         g_reg          <= g_next;
         rw_reg         <= rw_next;
         len_reg        <= len_next;
         chain_reg      <= chain_next;
         pend_rw_reg    <= pend_rw_next;
         pend_len_reg   <= pend_len_next;
         pend_chain_reg <= pend_chain_next;
         cnt_reg        <= cnt_next;
         last_reg       <= last_next;
         fall_reg       <= fall_next;
         ack_reg        <= ack_next;
         done_reg       <= done_next;
         err_reg        <= err_next;
         en_reg         <= en_next;
         rs_reg         <= rs_next;
         sync_q         <= sync_in;
         sync_qq        <= sync_q;
      end
   end

   assign ack_o            = ack_reg;
   assign done_o           = done_reg;
   assign err_o            = err_reg;
   assign busy_o           = (state_reg != ST_IDLE);
   assign m_enable_o       = en_reg;
   assign m_repeat_start_o = rs_reg;
   assign m_rw_o           = rw_reg;
   assign m_full_o         = (last_reg && rw_reg) || fifo_full_i;
   assign m_empty_o        = (last_reg && !rw_reg) || fifo_empty_i;

endmodule
